rf_wb_arbiter: RTL and testbench

- Shares the two register-file write ports (W1 = port A, W2 = port B) among NREQ writeback requesters, e.g. ALU, MULT, LSU and APU/FPU.
- Round-robin arbitration grants up to two requesters per cycle, with valid/ready handshakes and registered write-port outputs.
- An optional scoreboard tracks in-flight destination registers and flags read-after-write and write-after-write hazards to the decoder.
- Sits between the EX/WB result sources and the register file.

---
 rtl/cv32e40p_rf_arb_pkg.sv | 32 +++
 rtl/rf_wb_scoreboard.sv | 49 ++++
 rtl/rf_wb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_rf_arb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// rr_first_idx is the round-robin scan used by both write-port grant slots.
package cv32e40p_rf_arb_pkg;

  localparam int unsigned RF_X0_ADDR    = 0;
  localparam int unsigned RF_ADDR_WIDTH = 6;
  localparam int unsigned RF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [RF_DATA_WIDTH-1:0] data;
  } rf_wb_req_t;

  // Returns {found, index} of the first set bit of (valid & mask), scanning
  // start, start+1, ... modulo n. Vectors are sized for the maximum of 8 requesters.
  function automatic logic [3:0] rr_first_idx(input logic [7:0]  valid,
                                              input logic [2:0]  start,
                                              input logic [7:0]  mask,
                                              input int unsigned n);
    logic [3:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = (32'(start) + k) % n;
      if ((k < n) && !res[3] && valid[idx[2:0]] && mask[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_wb_scoreboard.sv
// Busy-bit table over all register addresses; flags RAW on operand reads and WAW on issue.
// Lookups are combinational from busy_q only; a same-cycle issue beats a same-cycle writeback clear.
module rf_wb_scoreboard
  import cv32e40p_rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  output logic                  issue_hazard_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o,
  output logic                  hazard_c_o
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (we_a_i) busy_d[waddr_a_i] = 1'b0;
    if (we_b_i) busy_d[waddr_b_i] = 1'b0;
    // Applied last so a younger issue survives the retiring write of the same register.
    if (issue_valid_i && (issue_addr_i != ADDR_WIDTH'(RF_X0_ADDR)) && !busy_q[issue_addr_i]) begin
      busy_d[issue_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign issue_hazard_o = busy_q[issue_addr_i];
  assign hazard_a_o     = busy_q[raddr_a_i];
  assign hazard_b_o     = busy_q[raddr_b_i];
  assign hazard_c_o     = busy_q[raddr_c_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter granting up to two writeback requesters per cycle onto register-file ports W1/W2.
// Grants are combinational, port writes registered (1 cycle); optional scoreboard via CV32E40P_RF_SCOREBOARD_EN.
module rf_wb_arbiter
  import cv32e40p_rf_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            wb_valid_i,
  output logic [NREQ-1:0]            wb_ready_o,
  input  logic [NREQ*ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [NREQ*DATA_WIDTH-1:0] wb_data_i,
  output logic [ADDR_WIDTH-1:0]      waddr_a_o,
  output logic [DATA_WIDTH-1:0]      wdata_a_o,
  output logic                       we_a_o,
  output logic [ADDR_WIDTH-1:0]      waddr_b_o,
  output logic [DATA_WIDTH-1:0]      wdata_b_o,
  output logic                       we_b_o,
  input  logic                       issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]      issue_addr_i,
  output logic                       issue_hazard_o,
  input  logic [ADDR_WIDTH-1:0]      raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]      raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]      raddr_c_i,
  output logic                       hazard_a_o,
  output logic                       hazard_b_o,
  output logic                       hazard_c_o
);

  localparam int unsigned RR_W = $clog2(NREQ);

  logic [RR_W-1:0]       rr_q, rr_d;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
  logic                  we_a_q, we_a_d, we_b_q, we_b_d;

  logic [ADDR_WIDTH-1:0] addr_arr [NREQ];
  logic [DATA_WIDTH-1:0] data_arr [NREQ];
  logic [7:0]            valid8, mask2;
  logic [3:0]            s1, s2;
  logic                  g1_vld, g2_vld;
  logic [2:0]            g1_idx, g2_idx;
  logic [ADDR_WIDTH-1:0] addr1, addr2;
  logic [DATA_WIDTH-1:0] data1, data2;
  logic [NREQ-1:0]       grant;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_arr[i] = wb_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[i] = wb_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    valid8             = '0;
    valid8[NREQ-1:0]   = wb_valid_i;
    s1                 = rr_first_idx(valid8, 3'(rr_q), 8'hFF, NREQ);
    g1_vld             = s1[3];
    g1_idx             = s1[2:0];
    addr1              = '0;
    data1              = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (3'(i) == g1_idx) begin
        addr1 = addr_arr[i];
        data1 = data_arr[i];
      end
    end
    // Slot 2 continues the scan after slot 1, skipping anyone targeting slot 1's register.
    mask2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      mask2[i] = (3'(i) != g1_idx) && (addr_arr[i] != addr1);
    end
    s2     = rr_first_idx(valid8, 3'((32'(g1_idx) + 1) % NREQ), mask2, NREQ);
    g2_vld = g1_vld & s2[3];
    g2_idx = s2[2:0];
    addr2  = '0;
    data2  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (3'(i) == g2_idx) begin
        addr2 = addr_arr[i];
        data2 = data_arr[i];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant[i] = (g1_vld && (3'(i) == g1_idx)) || (g2_vld && (3'(i) == g2_idx));
    end
  end

  always_comb begin
    rr_d      = rr_q;
    waddr_a_d = waddr_a_q;
    wdata_a_d = wdata_a_q;
    we_a_d    = 1'b0;
    waddr_b_d = waddr_b_q;
    wdata_b_d = wdata_b_q;
    we_b_d    = 1'b0;
    if (g2_vld)      rr_d = RR_W'((32'(g2_idx) + 1) % NREQ);
    else if (g1_vld) rr_d = RR_W'((32'(g1_idx) + 1) % NREQ);
    if (g1_vld) begin
      waddr_a_d = addr1;
      wdata_a_d = data1;
      we_a_d    = (addr1 != ADDR_WIDTH'(RF_X0_ADDR));
    end
    if (g2_vld) begin
      waddr_b_d = addr2;
      wdata_b_d = data2;
      we_b_d    = (addr2 != ADDR_WIDTH'(RF_X0_ADDR));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      we_a_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      we_b_q    <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      we_a_q    <= we_a_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
      we_b_q    <= we_b_d;
    end
  end

  // Reset gates ready so no requester believes it was accepted while flops are held.
  assign wb_ready_o = grant & {NREQ{rst_n}};
  assign waddr_a_o  = waddr_a_q;
  assign wdata_a_o  = wdata_a_q;
  assign we_a_o     = we_a_q;
  assign waddr_b_o  = waddr_b_q;
  assign wdata_b_o  = wdata_b_q;
  assign we_b_o     = we_b_q;

`ifdef CV32E40P_RF_SCOREBOARD_EN
  rf_wb_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .we_a_i        (we_a_q),
    .waddr_a_i     (waddr_a_q),
    .we_b_i        (we_b_q),
    .waddr_b_i     (waddr_b_q),
    .issue_valid_i (issue_valid_i),
    .issue_addr_i  (issue_addr_i),
    .issue_hazard_o(issue_hazard_o),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .raddr_c_i     (raddr_c_i),
    .hazard_a_o    (hazard_a_o),
    .hazard_b_o    (hazard_b_o),
    .hazard_c_o    (hazard_c_o)
  );
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{issue_valid_i, issue_addr_i, raddr_a_i, raddr_b_i, raddr_c_i};
  assign issue_hazard_o   = 1'b0;
  assign hazard_a_o       = 1'b0;
  assign hazard_b_o       = 1'b0;
  assign hazard_c_o       = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected port writes queued at grant time, popped by a monitor.
module tb_rf_wb_arbiter;
  import cv32e40p_rf_arb_pkg::*;

  logic        clk, rst_n;
  logic [3:0]  wb_valid;
  logic [3:0]  wb_ready_o;
  logic [5:0]  addr_r [4];
  logic [31:0] data_r [4];
  logic [23:0] wb_addr_i;
  logic [127:0] wb_data_i;
  logic [5:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic        we_a_o, we_b_o;
  logic        issue_valid;
  logic [5:0]  issue_addr, raddr_a, raddr_b, raddr_c;
  logic        issue_hazard_o, hazard_a_o, hazard_b_o, hazard_c_o;

  int checks = 0;
  int errors = 0;
  rf_wb_req_t qa[$];
  rf_wb_req_t qb[$];
  logic [31:0] rf [64];

  assign wb_addr_i = {addr_r[3], addr_r[2], addr_r[1], addr_r[0]};
  assign wb_data_i = {data_r[3], data_r[2], data_r[1], data_r[0]};

  rf_wb_arbiter #(.NREQ(4), .ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid_i(wb_valid), .wb_ready_o(wb_ready_o),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
    .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
    .issue_valid_i(issue_valid), .issue_addr_i(issue_addr), .issue_hazard_o(issue_hazard_o),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o), .hazard_c_o(hazard_c_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [31:0] d);
    addr_r[i] = a;
    data_r[i] = d;
  endtask

  task automatic push_a(input logic [5:0] a, input logic [31:0] d);
    qa.push_back('{addr: a, data: d});
  endtask

  task automatic push_b(input logic [5:0] a, input logic [31:0] d);
    qb.push_back('{addr: a, data: d});
  endtask

  // exp_haz bits: {issue_hazard, hazard_a, hazard_b, hazard_c}
  task automatic step(input logic [3:0] v, input logic [3:0] exp_rdy,
                      input logic [3:0] exp_haz, input string nm);
    wb_valid = v;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(wb_ready_o), 32'(exp_rdy));
    chk({nm, "_haz"}, 32'({issue_hazard_o, hazard_a_o, hazard_b_o, hazard_c_o}), 32'(exp_haz));
    @(posedge clk);
    #1;
  endtask

  // Register-file model written only through the DUT's enabled ports.
  always @(posedge clk) begin
    if (we_a_o) rf[waddr_a_o] <= wdata_a_o;
    if (we_b_o) rf[waddr_b_o] <= wdata_b_o;
  end

  always @(negedge clk) begin
    rf_wb_req_t e;
    if (rst_n) begin
      if (we_a_o) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL port_a_write actual=%0d:%h required=no_write", waddr_a_o, wdata_a_o);
        end else begin
          e = qa.pop_front();
          if (waddr_a_o !== e.addr || wdata_a_o !== e.data) begin
            errors++;
            $display("FAIL port_a_write actual=%0d:%h required=%0d:%h", waddr_a_o, wdata_a_o, e.addr, e.data);
          end
        end
      end
      if (we_b_o) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL port_b_write actual=%0d:%h required=no_write", waddr_b_o, wdata_b_o);
        end else begin
          e = qb.pop_front();
          if (waddr_b_o !== e.addr || wdata_b_o !== e.data) begin
            errors++;
            $display("FAIL port_b_write actual=%0d:%h required=%0d:%h", waddr_b_o, wdata_b_o, e.addr, e.data);
          end
        end
      end
      if (we_a_o && we_b_o) chk("ports_same_addr", 32'(waddr_a_o == waddr_b_o), 32'd0);
    end
  end

  initial begin
    for (int r = 0; r < 64; r++) rf[r] = '0;
    for (int i = 0; i < 4; i++) set_req(i, 6'd0, 32'd0);
    rst_n = 1'b0;
    issue_valid = 1'b0;
    issue_addr = '0;
    raddr_a = '0;
    raddr_b = '0;
    raddr_c = '0;
    wb_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(wb_ready_o), 32'd0);
    chk("rst_we_a", 32'(we_a_o), 32'd0);
    chk("rst_we_b", 32'(we_b_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    raddr_a = 6'd9;
    step(4'b0000, 4'b0000, 4'b0000, "release_idle");
    chk("release_we_a", 32'(we_a_o), 32'd0);

    // rr=0: slots 0 and 2, rr -> 3
    set_req(0, 6'd3, 32'hA000_0003);
    set_req(2, 6'd7, 32'hA200_0007);
    push_a(6'd3, 32'hA000_0003);
    push_b(6'd7, 32'hA200_0007);
    step(4'b0101, 4'b0101, 4'b0000, "rr_two_grant");

    // rr=3: req0 wins, req1 same address waits; rr -> 1
    set_req(0, 6'd5, 32'hB000_0005);
    set_req(1, 6'd5, 32'hB100_0005);
    push_a(6'd5, 32'hB000_0005);
    step(4'b0011, 4'b0001, 4'b0000, "same_addr_skip");
    push_a(6'd5, 32'hB100_0005);
    step(4'b0010, 4'b0010, 4'b0000, "deferred_grant");

    // x0 write: accepted, never enabled; rr -> 3
    set_req(2, 6'd0, 32'hDEAD_0000);
    step(4'b0100, 4'b0100, 4'b0000, "x0_handshake");
    set_req(3, 6'd21, 32'hA300_0015);
    push_a(6'd21, 32'hA300_0015);
    step(4'b1000, 4'b1000, 4'b0000, "single_req3");
    step(4'b0000, 4'b0000, 4'b0000, "idle_hold");

    // Everyone valid from rr=0: {0,1}, {2,3}, {0,1}
    for (int i = 0; i < 4; i++) set_req(i, 6'(10 + i), 32'hC000_0000 + 32'(i));
    push_a(6'd10, 32'hC000_0000);
    push_b(6'd11, 32'hC000_0001);
    step(4'b1111, 4'b0011, 4'b0000, "rot_01");
    set_req(0, 6'd10, 32'hD000_0000);
    set_req(1, 6'd11, 32'hD000_0001);
    push_a(6'd12, 32'hC000_0002);
    push_b(6'd13, 32'hC000_0003);
    step(4'b1111, 4'b1100, 4'b0000, "rot_23");
    set_req(2, 6'd12, 32'hD000_0002);
    set_req(3, 6'd13, 32'hD000_0003);
    push_a(6'd10, 32'hD000_0000);
    push_b(6'd11, 32'hD000_0001);
    step(4'b1111, 4'b0011, 4'b0000, "rot_01_again");
    step(4'b0000, 4'b0000, 4'b0000, "drain");
    @(negedge clk);
    chk("idle_we_a", 32'(we_a_o), 32'd0);
    chk("idle_hold_addr_a", 32'(waddr_a_o), 32'd10);
    chk("rf_r5", rf[5], 32'hB100_0005);
    chk("rf_r13", rf[13], 32'hC000_0003);
    @(posedge clk);
    #1;

`ifdef CV32E40P_RF_SCOREBOARD_EN
    raddr_a = 6'd9;
    raddr_b = 6'd9;
    raddr_c = 6'd4;
    issue_addr = 6'd9;
    issue_valid = 1'b1;
    step(4'b0000, 4'b0000, 4'b0000, "sb_issue");
    issue_valid = 1'b0;
    step(4'b0000, 4'b0000, 4'b1110, "sb_raw_set");
    issue_valid = 1'b1;
    step(4'b0000, 4'b0000, 4'b1110, "sb_waw_ignored");
    issue_valid = 1'b0;
    set_req(0, 6'd9, 32'hE000_0009);
    push_a(6'd9, 32'hE000_0009);
    step(4'b0001, 4'b0001, 4'b1110, "sb_wb_req");
    step(4'b0000, 4'b0000, 4'b1110, "sb_we_cycle");
    step(4'b0000, 4'b0000, 4'b0000, "sb_cleared");
    set_req(0, 6'd9, 32'hE100_0009);
    push_a(6'd9, 32'hE100_0009);
    step(4'b0001, 4'b0001, 4'b0000, "sb_wb_again");
    issue_valid = 1'b1;
    step(4'b0000, 4'b0000, 4'b0000, "sb_issue_with_we");
    issue_valid = 1'b0;
    step(4'b0000, 4'b0000, 4'b1110, "sb_set_wins");
`else
    raddr_a = 6'd9;
    raddr_b = 6'd9;
    raddr_c = 6'd9;
    issue_addr = 6'd9;
    issue_valid = 1'b1;
    step(4'b0000, 4'b0000, 4'b0000, "nosb_issue");
    issue_valid = 1'b0;
    step(4'b0000, 4'b0000, 4'b0000, "nosb_hazard");
`endif

    // Reset in the middle of a pending request drops it and clears all state.
    set_req(0, 6'd30, 32'hF000_001E);
    wb_valid = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(wb_ready_o), 32'd0);
    chk("midrst_we_a", 32'(we_a_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_a(6'd30, 32'hF000_001E);
    step(4'b0001, 4'b0001, 4'b0000, "post_rst_grant");
    step(4'b0000, 4'b0000, 4'b0000, "post_rst_drain");
    step(4'b0000, 4'b0000, 4'b0000, "final_idle");

    chk("queue_a_empty", 32'(qa.size()), 32'd0);
    chk("queue_b_empty", 32'(qb.size()), 32'd0);
    chk("rf_r0", rf[0], 32'd0);
    chk("rf_r30", rf[30], 32'hF000_001E);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
